mem_responder: RTL and testbench

//  Data-memory responder for the multi-cycle CPU.

---
 rtl/mem_resp_pkg.sv | 34 +++
 rtl/mem_resp_ram.sv | 38 +++
 rtl/mem_responder.sv | 150 +++++++++++++++
 tb/tb_mem_responder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg
//   Shared types and helpers for the data-memory responder.
//   Contents:
//     state_t   - responder FSM states IDLE / WAIT / RESP
//     BE_*      - the three byte-enable patterns the datapath may issue
//     be_legal  - alignment check of a byte-enable pattern against addr[1:0]
//     lane_mask32 - widens a 4-bit lane mask to a 32-bit bit mask
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // A halfword must sit on an even byte, a word on a word boundary.
  function automatic logic be_legal(input logic [3:0] be, input logic [1:0] off);
    case (be)
      BE_BYTE: be_legal = 1'b1;
      BE_HALF: be_legal = ~off[0];
      BE_WORD: be_legal = (off == 2'b00);
      default: be_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] lane_mask32(input logic [3:0] lanes);
    lane_mask32 = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
  endfunction

endpackage

// File: rtl/mem_resp_ram.sv
// mem_resp_ram
//   MEM_WORDS x 32-bit data array with a synchronous per-byte-lane write
//   and a combinational read. Contents are never reset.
//   Ports:
//     clk_i    - clock, writes on posedge
//     we_i     - write strobe
//     lanes_i  - byte lanes to update when we_i is high
//     addr_i   - word index
//     wdata_i  - lane-aligned write data
//     rdata_o  - word at addr_i (combinational)
module mem_resp_ram #(
  parameter int MEM_WORDS = 1024,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [3:0]    lanes_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [MEM_WORDS];

  // Only the selected lanes are written; the rest of the word keeps its value.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int l = 0; l < 4; l++) begin
        if (lanes_i[l]) begin
          mem_q[addr_i][8*l +: 8] <= wdata_i[8*l +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_responder.sv
// mem_responder
//   Data-memory responder for the multi-cycle CPU. Accepts one load/store at
//   a time, waits LATENCY cycles, then pulses resp_valid for one cycle with
//   right-aligned load data or an error flag.
//   Ports:
//     CLK, RST   - clock, asynchronous active-high reset
//     req_*      - request (valid, write, byte address, store data, byte enables)
//     req_ready  - high in IDLE, request accepted on req_valid & req_ready
//     resp_valid - one-cycle response strobe
//     resp_rdata - load data (0 for stores and errors), held until next response
//     resp_err   - misaligned / illegal BE / out-of-range, held until next response
//   Build option: define MEM_RESP_TRACE_EN to print one line per response.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q;

  logic        cur_write;
  logic [31:0] cur_addr, cur_wdata;
  logic [3:0]  cur_be;
  logic [1:0]  off;
  logic        in_range, access_err, enter_resp;
  logic [3:0]  lanes;
  logic [31:0] ram_rdata, load_data;

  // With LATENCY==0 the response is produced on the accept edge itself, so
  // in IDLE the live request is used instead of the (not yet loaded) latches.
  assign cur_write = (state_q == IDLE) ? req_write : write_q;
  assign cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign cur_be    = (state_q == IDLE) ? req_be    : be_q;

  assign off        = cur_addr[1:0];
  assign in_range   = (cur_addr[31:2] < 30'(MEM_WORDS));
  assign access_err = ~be_legal(cur_be, off) | ~in_range;
  assign lanes      = cur_be << off;
  assign enter_resp = (state_d == RESP);

  assign load_data    = (ram_rdata >> {off, 3'b000}) & lane_mask32(cur_be);
  assign resp_rdata_d = (cur_write || access_err) ? 32'd0 : load_data;

  // RST gates the write so a reset arriving before the RESP edge drops the store.
  mem_resp_ram #(
    .MEM_WORDS(MEM_WORDS),
    .AW       (AW)
  ) u_ram (
    .clk_i  (CLK),
    .we_i   (enter_resp & cur_write & ~access_err & ~RST),
    .lanes_i(lanes),
    .addr_i (cur_addr[AW+1:2]),
    .wdata_i(cur_wdata << {off, 3'b000}),
    .rdata_o(ram_rdata)
  );

  // Next-state logic: IDLE accepts, WAIT counts down, RESP lasts one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, request latches and registered response fields.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      write_q      <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      be_q         <= 4'd0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && req_valid) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
      if (enter_resp) begin
        resp_rdata_q <= resp_rdata_d;
        resp_err_q   <= access_err;
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

`ifdef MEM_RESP_TRACE_EN
  always @(posedge CLK) begin
    if (state_q == RESP) begin
      $display("[mem_responder] t=%0t %s addr=%h be=%b wdata=%h rdata=%h err=%b",
               $time, write_q ? "W" : "R", addr_q, be_q, wdata_q, resp_rdata, resp_err);
    end
  end
`else
  // Default build: no trace output.
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Drives two responders (LATENCY=2 and LATENCY=0) sharing clock and reset,
//   and compares every response against a byte-addressed reference memory.
module tb_mem_responder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        reqValid  [2];
  logic        reqWrite  [2];
  logic [31:0] reqAddr   [2];
  logic [31:0] reqWdata  [2];
  logic [3:0]  reqBe     [2];
  logic        reqReady  [2];
  logic        respValid [2];
  logic [31:0] respRdata [2];
  logic        respErr   [2];

  int checks = 0;
  int fails  = 0;
  int lat [2] = '{2, 0};

  // Reference memory: plain bytes per DUT, address = byte address.
  bit [7:0] modelMem [2][4096];

  always #5 CLK = ~CLK;

  mem_responder #(.MEM_WORDS(1024), .LATENCY(2)) u_dut_lat2 (
    .CLK(CLK), .RST(RST),
    .req_valid(reqValid[0]), .req_write(reqWrite[0]), .req_addr(reqAddr[0]),
    .req_wdata(reqWdata[0]), .req_be(reqBe[0]), .req_ready(reqReady[0]),
    .resp_valid(respValid[0]), .resp_rdata(respRdata[0]), .resp_err(respErr[0])
  );

  mem_responder #(.MEM_WORDS(1024), .LATENCY(0)) u_dut_lat0 (
    .CLK(CLK), .RST(RST),
    .req_valid(reqValid[1]), .req_write(reqWrite[1]), .req_addr(reqAddr[1]),
    .req_wdata(reqWdata[1]), .req_be(reqBe[1]), .req_ready(reqReady[1]),
    .resp_valid(respValid[1]), .resp_rdata(respRdata[1]), .resp_err(respErr[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour: access size from BE, natural alignment, 4 KiB space.
  task automatic refOp(input int s, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       output bit err, output logic [31:0] rdata);
    int n;
    n = (be == 4'b0001) ? 1 : (be == 4'b0011) ? 2 : (be == 4'b1111) ? 4 : 0;
    if (n == 0) err = 1'b1;
    else        err = (addr % n != 0) || (addr >= 32'd4096);
    rdata = 32'd0;
    if (!err) begin
      for (int k = 0; k < n; k++) begin
        if (wr) modelMem[s][int'(addr) + k] = wdata[8*k +: 8];
        else    rdata[8*k +: 8] = modelMem[s][int'(addr) + k];
      end
    end
  endtask

  // One complete transaction: wait for ready, accept, time the response, compare.
  task automatic applyStimulus(input int s, input bit wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be,
                               output logic [31:0] obsData);
    bit          expErr;
    logic [31:0] expData;
    int          waited;
    int          cycles;
    refOp(s, wr, addr, wdata, be, expErr, expData);
    reqWrite[s] = wr;
    reqAddr[s]  = addr;
    reqWdata[s] = wdata;
    reqBe[s]    = be;
    reqValid[s] = 1'b1;
    waited = 0;
    while (!reqReady[s] && waited < 20) begin
      @(posedge CLK); #1;
      waited++;
    end
    checkOutput("ready_seen", 32'(reqReady[s]), 32'd1);
    @(posedge CLK); #1;
    reqValid[s] = 1'b0;
    cycles = 1;
    while (!respValid[s] && cycles < 40) begin
      @(posedge CLK); #1;
      cycles++;
    end
    checkOutput("resp_latency", 32'(cycles), 32'(lat[s] + 1));
    checkOutput("resp_err", 32'(respErr[s]), 32'(expErr));
    checkOutput("resp_rdata", respRdata[s], expData);
    obsData = respRdata[s];
    @(posedge CLK); #1;
    checkOutput("resp_single_pulse", 32'(respValid[s]), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] obs;
    logic [31:0] expList [8];
    bit          dummyErr;
    int          sent, got, cyc, lastResp, pulses;
    bit          rdy;

    for (int s = 0; s < 2; s++) begin
      reqValid[s] = 1'b0; reqWrite[s] = 1'b0; reqAddr[s] = '0;
      reqWdata[s] = '0;   reqBe[s] = 4'b0001;
    end

    // Reset state
    #2;
    for (int s = 0; s < 2; s++) begin
      checkOutput("rst_ready", 32'(reqReady[s]), 32'd1);
      checkOutput("rst_valid", 32'(respValid[s]), 32'd0);
      checkOutput("rst_rdata", respRdata[s], 32'd0);
      checkOutput("rst_err", 32'(respErr[s]), 32'd0);
    end
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(posedge CLK); #1;

    // Give words 0..15 of both arrays known contents.
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 16; w++)
        applyStimulus(s, 1'b1, 32'(4 * w), $urandom, 4'b1111, obs);

    // Word store and load on the LATENCY=2 responder.
    applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, obs);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'b1111, obs);
    checkOutput("lw_deadbeef", obs, 32'hDEADBEEF);

    // Byte store merged into a word, then byte load from another lane.
    applyStimulus(0, 1'b1, 32'h10, 32'h11223344, 4'b1111, obs);
    applyStimulus(0, 1'b1, 32'h13, 32'h000000AA, 4'b0001, obs);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'b1111, obs);
    checkOutput("sb_merge", obs, 32'hAA223344);
    applyStimulus(0, 1'b0, 32'h12, 32'h0, 4'b0001, obs);
    checkOutput("lb_lane2", obs, 32'h00000022);

    // Error cases and the top edge of the array.
    applyStimulus(0, 1'b1, 32'h11, 32'h0000FFFF, 4'b0011, obs);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'b1111, obs);
    checkOutput("sh_misaligned_no_write", obs, 32'hAA223344);
    applyStimulus(0, 1'b0, 32'h4002, 32'h0, 4'b1111, obs);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'b0111, obs);
    applyStimulus(0, 1'b0, 32'h1000, 32'h0, 4'b1111, obs);
    applyStimulus(0, 1'b1, 32'hFFC, 32'hCAFEF00D, 4'b1111, obs);
    applyStimulus(0, 1'b0, 32'hFFE, 32'h0, 4'b0011, obs);
    checkOutput("lh_last_word", obs, 32'h0000CAFE);

    // LATENCY=0 with req_valid held high: one accept every second cycle.
    for (int i = 0; i < 8; i++)
      refOp(1, 1'b0, 32'(4 * i), 32'h0, 4'b1111, dummyErr, expList[i]);
    sent = 0; got = 0; cyc = 0; lastResp = 0;
    reqWrite[1] = 1'b0; reqBe[1] = 4'b1111; reqAddr[1] = 32'h0; reqValid[1] = 1'b1;
    while (got < 8 && cyc < 60) begin
      rdy = reqReady[1];
      @(posedge CLK); #1;
      cyc++;
      if (rdy && reqValid[1]) begin
        sent++;
        if (sent < 8) reqAddr[1] = 32'(4 * sent);
        else          reqValid[1] = 1'b0;
      end
      if (respValid[1]) begin
        checkOutput("b2b_rdata", respRdata[1], expList[got]);
        if (got > 0) checkOutput("b2b_gap", 32'(cyc - lastResp), 32'd2);
        lastResp = cyc;
        got++;
      end
    end
    reqValid[1] = 1'b0;
    checkOutput("b2b_responses", 32'(got), 32'd8);
    checkOutput("b2b_accepts", 32'(sent), 32'd8);
    @(posedge CLK); #1;

    // Reset during WAIT drops the store.
    reqWrite[0] = 1'b1; reqAddr[0] = 32'h20; reqWdata[0] = 32'h5A5A5A5A;
    reqBe[0] = 4'b1111; reqValid[0] = 1'b1;
    @(posedge CLK); #1;
    reqValid[0] = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    #1;
    checkOutput("midrst_ready", 32'(reqReady[0]), 32'd1);
    checkOutput("midrst_valid", 32'(respValid[0]), 32'd0);
    checkOutput("midrst_rdata", respRdata[0], 32'd0);
    checkOutput("midrst_err", 32'(respErr[0]), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(posedge CLK); #1;
      if (respValid[0]) pulses++;
    end
    checkOutput("midrst_no_resp", 32'(pulses), 32'd0);
    applyStimulus(0, 1'b0, 32'h20, 32'h0, 4'b1111, obs);

    // Randomised mix against the reference memory.
    for (int i = 0; i < 80; i++) begin
      int          s;
      int          pick;
      logic [3:0]  be;
      logic [31:0] addr;
      s    = int'($urandom_range(0, 1));
      pick = int'($urandom_range(0, 7));
      be   = (pick < 2) ? 4'b0001 : (pick < 4) ? 4'b0011 : (pick < 7) ? 4'b1111 : 4'($urandom);
      if ($urandom_range(0, 7) == 0) addr = $urandom | 32'h1000;
      else                           addr = 32'($urandom_range(0, 63));
      applyStimulus(s, 1'($urandom), addr, $urandom, be, obs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
